// File: rtl/cnn_pkg.sv
// ============================================================================
// Module  : cnn_pkg
// Brief   : Shared types and helpers for the CNN pixel pipeline stages.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

    // Default pixel width used by the pipeline stages.
    localparam int WORD_SIZE_DEF = 8;

    typedef logic [WORD_SIZE_DEF-1:0] pixel_t;

    // Row phase of the 2x2 pooling window.
    typedef enum logic [0:0] {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } pool_state_t;

    // Unsigned maximum of two default-width pixels.
    function automatic pixel_t pixel_max(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/max_pool_2x2_if.sv
// ============================================================================
// Module  : max_pool_2x2_if
// Brief   : Pixel stream bundle between the convolution stage and the 2x2
//           pooling stage (pixel in, valid in, pooled pixel out, valid out).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface max_pool_2x2_if #(
    parameter int WORD_SIZE = cnn_pkg::WORD_SIZE_DEF
);
    logic [WORD_SIZE-1:0] inputPixel;
    logic [1:0]           inputValid;
    logic [WORD_SIZE-1:0] outputPixel;
    logic [1:0]           valid;

    // Upstream/consumer side: drives the input stream, observes pooled output.
    modport master (
        output inputPixel,
        output inputValid,
        input  outputPixel,
        input  valid
    );

    // Pooling stage side.
    modport slave (
        input  inputPixel,
        input  inputValid,
        output outputPixel,
        output valid
    );
endinterface

`default_nettype wire

// File: rtl/max_pool_2x2_line_buffer.sv
// ============================================================================
// Module  : pool_line_buffer
// Brief   : Simple dual-port register array holding one row of horizontal
//           pair results. Synchronous write, combinational read, storage is
//           not reset (every entry is written before it is read).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pool_line_buffer #(
    parameter int DEPTH = 269,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: store one pair result per enabled cycle.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/max_pool_2x2.sv
// ============================================================================
// Module  : max_pool_2x2
// Brief   : Streaming 2x2 / stride-2 pooling of the convolution output.
//           Even rows store horizontal pair results in a line buffer; odd
//           rows combine their pair result with the stored one and emit a
//           registered pooled pixel with a one-cycle valid pulse.
//           Build option POOL_AVG_EN: average pooling instead of max pooling.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module max_pool_2x2
    import cnn_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int ROW_SIZE  = 538
) (
    input  logic              clk,
    input  logic              rst,
    max_pool_2x2_if.slave     bus
);

    localparam int OUT_ROW_SIZE = ROW_SIZE / 2;
    localparam int CW           = $clog2(ROW_SIZE);
    localparam int AW           = (OUT_ROW_SIZE > 1) ? $clog2(OUT_ROW_SIZE) : 1;
`ifdef POOL_AVG_EN
    // Pair sums need one extra bit so nothing is lost before the final divide.
    localparam int LB_WIDTH     = WORD_SIZE + 1;
`else
    localparam int LB_WIDTH     = WORD_SIZE;
`endif

    localparam logic [0:0]    C_ROW_EVEN = ROW_EVEN;
    localparam logic [0:0]    C_ROW_ODD  = ROW_ODD;
    localparam logic [CW-1:0] C_LAST_COL = CW'(ROW_SIZE - 1);

    logic [CW-1:0]        r_col;
    logic [0:0]           r_state;
    logic [WORD_SIZE-1:0] r_pair;
    logic [WORD_SIZE-1:0] r_out;
    logic                 r_valid;

    logic                 w_accept;
    logic                 w_odd_col;
    logic                 w_row_end;
    logic                 w_latch_pair;
    logic                 w_wr_en;
    logic [AW-1:0]        w_addr;
    logic [LB_WIDTH-1:0]  w_pair;
    logic [LB_WIDTH-1:0]  w_rd_data;
    logic [WORD_SIZE-1:0] w_pool;
    logic                 w_unused_valid_hi;

    assign w_accept          = bus.inputValid[0];
    assign w_unused_valid_hi = bus.inputValid[1];
    assign w_odd_col         = r_col[0];
    assign w_row_end         = (r_col == C_LAST_COL);
    // With an odd row width the last (even) column has no partner: skip it.
    assign w_latch_pair      = w_accept && !w_odd_col && !w_row_end;
    assign w_wr_en           = w_accept && w_odd_col && (r_state == C_ROW_EVEN);
    assign w_addr            = AW'(r_col >> 1);

`ifdef POOL_AVG_EN
    logic [WORD_SIZE+1:0] w_sum;
    logic [1:0]           w_unused_frac;

    assign w_pair = {1'b0, r_pair} + {1'b0, bus.inputPixel};
    assign w_sum  = {1'b0, w_pair} + {1'b0, w_rd_data};
    // Divide by four by dropping the two fraction bits (truncation).
    assign {w_pool, w_unused_frac} = w_sum;
`else
    assign w_pair = (r_pair > bus.inputPixel) ? r_pair : bus.inputPixel;
    assign w_pool = (w_pair > w_rd_data) ? w_pair : w_rd_data;
`endif

    pool_line_buffer #(
        .DEPTH (OUT_ROW_SIZE),
        .WIDTH (LB_WIDTH),
        .AW    (AW)
    ) u_line_buf (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_addr),
        .i_wr_data (w_pair),
        .i_rd_addr (w_addr),
        .o_rd_data (w_rd_data)
    );

    // Column counter and row phase: advance only on accepted pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col   <= '0;
            r_state <= C_ROW_EVEN;
        end else if (w_accept) begin
            if (w_row_end) begin
                r_col   <= '0;
                r_state <= (r_state == C_ROW_EVEN) ? C_ROW_ODD : C_ROW_EVEN;
            end else begin
                r_col   <= r_col + 1'b1;
            end
        end
    end

    // Pair register: first pixel of each horizontal pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pair <= '0;
        end else if (w_latch_pair) begin
            r_pair <= bus.inputPixel;
        end
    end

    // Output register: pooled result on odd rows, single-cycle valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept && w_odd_col && (r_state == C_ROW_ODD)) begin
                r_out   <= w_pool;
                r_valid <= 1'b1;
            end
        end
    end

    assign bus.outputPixel = r_out;
    assign bus.valid       = {1'b0, r_valid};

endmodule

`default_nettype wire

// File: tb/tb_max_pool_2x2.sv
// ============================================================================
// Module  : tb_max_pool_2x2
// Brief   : Directed, table-driven bench for max_pool_2x2. Two instances
//           (row width 4 and 5) share one input stream; each test resets
//           both and checks only the instance it targets.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_max_pool_2x2;

    logic       clk;
    logic       rst;
    logic [7:0] tb_pix;
    logic [1:0] tb_vld;

    int checks;
    int failures;

    logic [7:0] q4 [$];
    logic [7:0] q5 [$];

    max_pool_2x2_if #(.WORD_SIZE(8)) if4 ();
    max_pool_2x2_if #(.WORD_SIZE(8)) if5 ();

    assign if4.inputPixel = tb_pix;
    assign if4.inputValid = tb_vld;
    assign if5.inputPixel = tb_pix;
    assign if5.inputValid = tb_vld;

    max_pool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    max_pool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(5)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (if5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every non-idle valid observed between clock edges.
    always @(negedge clk) begin
        if (if4.valid !== 2'b00) q4.push_back(if4.outputPixel);
        if (if5.valid !== 2'b00) q5.push_back(if5.outputPixel);
    end

    typedef struct packed {
        logic [7:0][7:0] pix;
        logic            gaps;
        logic [7:0]      e0;
        logic [7:0]      e1;
    } vec_t;

    vec_t vecs [5];

    function automatic vec_t mk(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7,
                                input logic g, input logic [7:0] e0, e1);
        vec_t v;
        v.pix[0] = a0; v.pix[1] = a1; v.pix[2] = a2; v.pix[3] = a3;
        v.pix[4] = a4; v.pix[5] = a5; v.pix[6] = a6; v.pix[7] = a7;
        v.gaps = g;
        v.e0   = e0;
        v.e1   = e1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic drive_pix(input logic [7:0] p, input int gap);
        for (int g = 0; g < gap; g++) begin
            tb_vld = 2'b10;
            tb_pix = 8'($urandom);
            @(posedge clk); #1;
        end
        tb_pix = p;
        tb_vld = {1'($urandom), 1'b1};
        @(posedge clk); #1;
        tb_vld = 2'b00;
        tb_pix = 8'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        tb_vld = 2'b00;
        rst    = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        q4.delete();
        q5.delete();
    endtask

    logic [7:0] r5_pix [10];
    logic [7:0] rm_pix [8];
    logic [7:0] e5_a, e5_b, pre_v, rm_e;

    initial begin
        checks   = 0;
        failures = 0;
        tb_pix   = 8'd0;
        tb_vld   = 2'b00;
        rst      = 1'b0;

`ifdef POOL_AVG_EN
        vecs[0] = mk(8'd1, 8'd5, 8'd2, 8'd3, 8'd4, 8'd0, 8'd9, 8'd7, 1'b0, 8'd2, 8'd5);
        vecs[1] = mk(8'd1, 8'd5, 8'd2, 8'd3, 8'd4, 8'd0, 8'd9, 8'd7, 1'b1, 8'd2, 8'd5);
        vecs[2] = mk(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 8'd255, 8'd255);
        vecs[3] = mk(8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 1'b1, 8'd0, 8'd0);
        vecs[4] = mk(8'd200, 8'd100, 8'd50, 8'd60, 8'd10, 8'd20, 8'd255, 8'd0, 1'b1, 8'd82, 8'd91);
        e5_a  = 8'd3;  e5_b = 8'd5;
        pre_v = 8'd75; rm_e = 8'd5;
`else
        vecs[0] = mk(8'd1, 8'd5, 8'd2, 8'd3, 8'd4, 8'd0, 8'd9, 8'd7, 1'b0, 8'd5, 8'd9);
        vecs[1] = mk(8'd1, 8'd5, 8'd2, 8'd3, 8'd4, 8'd0, 8'd9, 8'd7, 1'b1, 8'd5, 8'd9);
        vecs[2] = mk(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 8'd255, 8'd255);
        vecs[3] = mk(8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 1'b1, 8'd1, 8'd1);
        vecs[4] = mk(8'd200, 8'd100, 8'd50, 8'd60, 8'd10, 8'd20, 8'd255, 8'd0, 1'b1, 8'd200, 8'd255);
        e5_a  = 8'd6;   e5_b = 8'd8;
        pre_v = 8'd100; rm_e = 8'd9;
`endif
        r5_pix = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd250, 8'd5, 8'd6, 8'd7, 8'd8, 8'd250};
        rm_pix = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd1, 8'd1, 8'd1, 8'd1};

        // Asynchronous reset before any clock edge.
        #3 rst = 1'b1;
        #1;
        check("reset_valid4", 32'(if4.valid), 32'd0);
        check("reset_pixel4", 32'(if4.outputPixel), 32'd0);
        check("reset_valid5", 32'(if5.valid), 32'd0);
        check("reset_pixel5", 32'(if5.outputPixel), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven two-row tests on the width-4 instance.
        for (int t = 0; t < 5; t++) begin
            do_reset();
            for (int k = 0; k < 8; k++) begin
                drive_pix(vecs[t].pix[k], vecs[t].gaps ? int'($urandom_range(0, 3)) : 0);
                if (k == 4) check($sformatf("v%0d_nopulse_col0", t), 32'(if4.valid), 32'd0);
                if (k == 5) begin
                    check($sformatf("v%0d_valid0", t), 32'(if4.valid), 32'd1);
                    check($sformatf("v%0d_pixel0", t), 32'(if4.outputPixel), 32'(vecs[t].e0));
                end
                if (k == 7) begin
                    check($sformatf("v%0d_valid1", t), 32'(if4.valid), 32'd1);
                    check($sformatf("v%0d_pixel1", t), 32'(if4.outputPixel), 32'(vecs[t].e1));
                end
            end
            idle(2);
            check($sformatf("v%0d_pulse_count", t), 32'(q4.size()), 32'd2);
        end

        // Odd row width: trailing pixel of each row is discarded.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive_pix(r5_pix[k], 0);
            if (k == 6) begin
                check("w5_valid0", 32'(if5.valid), 32'd1);
                check("w5_pixel0", 32'(if5.outputPixel), 32'(e5_a));
            end
            if (k == 8) begin
                check("w5_valid1", 32'(if5.valid), 32'd1);
                check("w5_pixel1", 32'(if5.outputPixel), 32'(e5_b));
            end
            if (k == 9) check("w5_trailing_nopulse", 32'(if5.valid), 32'd0);
        end
        idle(2);
        check("w5_pulse_count", 32'(q5.size()), 32'd2);

        // Reset in the middle of an odd row, while a valid pulse is showing.
        do_reset();
        drive_pix(8'd50, 0);
        drive_pix(8'd60, 0);
        drive_pix(8'd70, 0);
        drive_pix(8'd80, 0);
        drive_pix(8'd90, 0);
        drive_pix(8'd100, 0);
        check("pre_reset_pixel", 32'(if4.outputPixel), 32'(pre_v));
        #2 rst = 1'b1;
        #1;
        check("async_reset_valid", 32'(if4.valid), 32'd0);
        check("async_reset_pixel", 32'(if4.outputPixel), 32'd0);
        tb_pix = 8'd123;
        tb_vld = 2'b01;
        @(posedge clk); #1;
        check("in_reset_valid_a", 32'(if4.valid), 32'd0);
        @(posedge clk); #1;
        check("in_reset_valid_b", 32'(if4.valid), 32'd0);
        tb_vld = 2'b00;
        rst    = 1'b0;
        q4.delete();
        for (int k = 0; k < 8; k++) begin
            drive_pix(rm_pix[k], 0);
            if (k == 3) check("post_reset_row0_nopulse", 32'(if4.valid), 32'd0);
            if (k == 5) check("post_reset_pixel0", 32'(if4.outputPixel), 32'(rm_e));
            if (k == 7) check("post_reset_pixel1", 32'(if4.outputPixel), 32'(rm_e));
        end
        idle(2);
        check("post_reset_pulse_count", 32'(q4.size()), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
